// File: rtl/eth_frame_matcher_pkg.sv
// Shared types for the Ethernet frame pattern matcher: FSM state encoding,
// the result record held in the output register, and saturation helpers.
package eth_frame_matcher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RX   = 2'd1,
        DROP = 2'd2
    } state_e;

    localparam int LEN_W        = 16;
    localparam int MAX_PATTERNS = 16;
    // Widest timestamp the result record can carry; C_TIME_WIDTH must not exceed it.
    localparam int MAX_TIME_W   = 64;
    localparam logic [LEN_W-1:0] CNT_MAX = 16'hFFFF;

    // Result record sized for the largest configuration; the top uses the low bits.
    typedef struct packed {
        logic [MAX_PATTERNS-1:0] bitmap;
        logic [MAX_TIME_W-1:0]   tstamp;
        logic [LEN_W-1:0]        length;
        logic                    fcs_err;
    } result_t;

    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/eth_pattern_lane.sv
// One pattern lane: data+mask byte memory, write port, async read at the
// current frame offset, and the per-frame "still matching" run flag.
module eth_pattern_lane
    import eth_frame_matcher_pkg::*;
#(
    parameter int C_PATTERN_LEN = 64,
    parameter int AW            = $clog2(C_PATTERN_LEN)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [7:0]    wr_mask,
    input  logic [AW-1:0] rd_addr,
    input  logic [7:0]    rx_data,
    input  logic          start,      // first byte of an accepted frame
    input  logic          step,       // later byte of the frame
    input  logic          cmp_en,     // offset lies inside the pattern
    input  logic          init_val,   // lane enable latched at frame start
    output logic          run_next_o  // run flag including the current byte
);

    logic [7:0] pat_mem  [C_PATTERN_LEN];
    logic [7:0] mask_mem [C_PATTERN_LEN];
    logic       run_q, run_d, run_cur, hit;

    // Pattern storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pat_mem[wr_addr]  <= wr_data;
            mask_mem[wr_addr] <= wr_mask;
        end
    end

    // Compare the current byte and fold it into the run flag.
    always_comb begin
        hit        = ((rx_data ^ pat_mem[rd_addr]) & mask_mem[rd_addr]) == 8'h00;
        run_cur    = start ? init_val : run_q;
        run_next_o = run_cur & (~cmp_en | hit);
        run_d      = (start | step) ? run_next_o : run_q;
    end

    // Run flag register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) run_q <= 1'b0;
        else         run_q <= run_d;
    end

endmodule

// File: rtl/eth_frame_pattern_matcher.sv
// Ethernet frame pattern matcher: compares each frame against C_NUM_PATTERNS
// masked patterns and emits one timestamped result per frame.
// Optional feature macro: ETH_FRAME_MATCHER_REPORT_ALL_EN (report zero-bitmap
// frames too). Result handshake: a result transfers on a cycle where
// m_match_valid and m_match_ready are both high; while valid is high and ready
// low, all m_match_* outputs hold stable.
module eth_frame_pattern_matcher
    import eth_frame_matcher_pkg::*;
#(
    parameter int C_NUM_PATTERNS = 4,
    parameter int C_PATTERN_LEN  = 64,
    parameter int C_TIME_WIDTH   = 64,
    parameter int PW = (C_NUM_PATTERNS > 1) ? $clog2(C_NUM_PATTERNS) : 1,
    parameter int AW = $clog2(C_PATTERN_LEN)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      cfg_we,
    input  logic [PW-1:0]             cfg_pattern,
    input  logic [AW-1:0]             cfg_addr,
    input  logic [7:0]                cfg_data,
    input  logic [7:0]                cfg_mask,
    input  logic [C_NUM_PATTERNS-1:0] cfg_enable,
    output logic                      cfg_busy,
    input  logic [7:0]                s_axis_tdata,
    input  logic                      s_axis_tuser,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tvalid,
    input  logic [C_TIME_WIDTH-1:0]   current_time,
    input  logic                      time_running,
    output logic                      m_match_valid,
    input  logic                      m_match_ready,
    output logic [C_NUM_PATTERNS-1:0] m_match_bitmap,
    output logic [C_TIME_WIDTH-1:0]   m_match_time,
    output logic [15:0]               m_match_length,
    output logic                      m_match_fcs_err,
    output logic [15:0]               overflow_count
);

    state_e                    state_q, state_d;
    logic [LEN_W-1:0]          byte_cnt_q, byte_cnt_d;
    logic [C_TIME_WIDTH-1:0]   time_q, time_d;
    logic                      start, step, fin, cmp_en, report;
    logic [LEN_W-1:0]          offset, fin_len;
    logic [C_NUM_PATTERNS-1:0] run_next;
    result_t                   res_q, res_d, res_new;
    logic                      valid_q, valid_d;
    logic [15:0]               ovf_q, ovf_d;

    // Pattern lanes; writes are only accepted while no frame is in progress.
    for (genvar g = 0; g < C_NUM_PATTERNS; g++) begin : g_lane
        eth_pattern_lane #(.C_PATTERN_LEN(C_PATTERN_LEN), .AW(AW)) u_lane (
            .clk        (clk),
            .resetn     (resetn),
            .wr_en      (cfg_we && !cfg_busy && (cfg_pattern == PW'(g))),
            .wr_addr    (cfg_addr),
            .wr_data    (cfg_data),
            .wr_mask    (cfg_mask),
            .rd_addr    (offset[AW-1:0]),
            .rx_data    (s_axis_tdata),
            .start      (start),
            .step       (step),
            .cmp_en     (cmp_en),
            .init_val   (cfg_enable[g]),
            .run_next_o (run_next[g])
        );
    end

    // Frame FSM: start/step/finish decode, byte counter, timestamp capture.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        time_d     = time_q;
        start      = 1'b0;
        step       = 1'b0;
        fin        = 1'b0;
        fin_len    = '0;
        case (state_q)
            IDLE: begin
                if (s_axis_tvalid) begin
                    if (time_running) begin
                        start      = 1'b1;
                        time_d     = current_time;
                        byte_cnt_d = 16'd1;
                        if (s_axis_tlast) begin
                            fin     = 1'b1;
                            fin_len = 16'd1;
                        end else begin
                            state_d = RX;
                        end
                    end else if (!s_axis_tlast) begin
                        state_d = DROP;
                    end
                end
            end
            RX: begin
                if (s_axis_tvalid) begin
                    step       = 1'b1;
                    byte_cnt_d = sat_inc(byte_cnt_q);
                    if (s_axis_tlast) begin
                        fin     = 1'b1;
                        fin_len = sat_inc(byte_cnt_q);
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (s_axis_tvalid && s_axis_tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        offset = (state_q == RX) ? byte_cnt_q : '0;
        cmp_en = offset < LEN_W'(C_PATTERN_LEN);
    end

    // Result holding register and overflow counter.
    always_comb begin
        res_new                           = '0;
        res_new.bitmap[C_NUM_PATTERNS-1:0] = run_next;
        res_new.tstamp[C_TIME_WIDTH-1:0]   = (state_q == IDLE) ? current_time : time_q;
        res_new.length                    = fin_len;
        res_new.fcs_err                   = s_axis_tuser;
`ifdef ETH_FRAME_MATCHER_REPORT_ALL_EN
        report = fin;
`else
        report = fin && (run_next != '0);
`endif
        res_d   = res_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (valid_q && m_match_ready) valid_d = 1'b0;
        if (report) begin
            if (valid_q && !m_match_ready) begin
                ovf_d = sat_inc(ovf_q);
            end else begin
                res_d   = res_new;
                valid_d = 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            time_q     <= '0;
            res_q      <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            time_q     <= time_d;
            res_q      <= res_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign cfg_busy        = (state_q != IDLE);
    assign m_match_valid   = valid_q;
    assign m_match_bitmap  = res_q.bitmap[C_NUM_PATTERNS-1:0];
    assign m_match_time    = res_q.tstamp[C_TIME_WIDTH-1:0];
    assign m_match_length  = res_q.length;
    assign m_match_fcs_err = res_q.fcs_err;
    assign overflow_count  = ovf_q;

endmodule

// File: doc/eth_frame_pattern_matcher.md
Name: eth_frame_pattern_matcher

Overview:
Single-clock, N-pattern successor to the fixed two-interface frame detector. It compares each received Ethernet frame byte-by-byte against C_NUM_PATTERNS programmable masked patterns. At frame end it emits one timestamped result: match bitmap, frame length and FCS status. It sits behind the TEMAC RX stream (after any CDC) and feeds the detector's log FIFO / AXI register block.

Parameters:
C_NUM_PATTERNS, 4, number of independent patterns (1..16)
C_PATTERN_LEN, 64, compared bytes per pattern, starting at frame byte 0 (power of two, 8..1024)
C_TIME_WIDTH, 64, timestamp width

Ports:
clk  in  1  block clock, all logic rising-edge
resetn  in  1  asynchronous active-low reset
cfg_we  in  1  pattern memory write strobe
cfg_pattern  in  clog2(C_NUM_PATTERNS)  pattern index for write
cfg_addr  in  clog2(C_PATTERN_LEN)  byte offset for write
cfg_data  in  8  pattern byte
cfg_mask  in  8  compare mask, bit=1 means compare
cfg_enable  in  C_NUM_PATTERNS  per-pattern enable, sampled at frame start
cfg_busy  out  1  high while a frame is in progress; writes ignored when high
s_axis_tdata  in  8  RX byte
s_axis_tuser  in  1  on tlast beat: 1 = bad FCS
s_axis_tlast  in  1  last byte of frame
s_axis_tvalid  in  1  byte valid (no backpressure)
current_time  in  C_TIME_WIDTH  free-running timer
time_running  in  1  capture enable
m_match_valid  out  1  result valid
m_match_ready  in  1  result accepted
m_match_bitmap  out  C_NUM_PATTERNS  bit p = pattern p matched
m_match_time  out  C_TIME_WIDTH  current_time at first byte
m_match_length  out  16  frame byte count, saturating at 0xFFFF
m_match_fcs_err  out  1  tuser on tlast beat
overflow_count  out  16  results dropped, saturating

Behaviour:
- Reset: all outputs 0; FSM in IDLE; pattern memory contents undefined (masks need not reset).
- FSM states:
  - IDLE: on tvalid & time_running, capture current_time, set byte_cnt=1, init run flags = cfg_enable, compare byte 0. Next state is RX; if tlast on the same beat, finish immediately.
  - IDLE with tvalid & !time_running: go to DROP unless tlast.
  - RX: on each tvalid, compare byte at offset byte_cnt; byte_cnt++ (saturating). On tlast, finish and return to IDLE.
  - DROP: discard bytes until tlast, then IDLE; no result, no counters touched.
- Compare rule: while offset < C_PATTERN_LEN, run[p] &= ((data ^ pat[p][off]) & mask[p][off]) == 0. Offsets >= C_PATTERN_LEN are not compared.
- Short frames: bytes beyond frame end are don't-care. A frame shorter than the pattern can therefore still match.
- Finish: bitmap = final run flags (including the tlast byte). The result is reported if bitmap != 0.
- Result latency: m_match_valid rises the cycle after the tlast beat. All m_match_* are registered and held stable until valid & ready.
- Single result holding register. If a new result must be written while valid is still high and ready is low on that cycle, the new result is dropped and overflow_count increments (saturating at 0xFFFF).
  - valid & ready on the same cycle as a new write: the new result loads; no drop.
- time_running falling mid-frame: frame completes normally (timestamp already captured).
- cfg_busy = (state != IDLE). cfg_we while busy is ignored. cfg_we in IDLE on the same cycle as a frame's first byte: the write is applied and the compare uses the old value.
- cfg_enable changes mid-frame have no effect until the next frame.

Optional Feature:
ETH_FRAME_MATCHER_REPORT_ALL_EN: when defined, every completed non-dropped frame produces a result, including bitmap == 0 (for traffic logging). When undefined, zero-bitmap frames produce no result and cannot cause overflow.

Decomposition:
- Package eth_frame_matcher_pkg: FSM state enum (IDLE, RX, DROP), result struct (bitmap, time, length, fcs_err), length-width and counter-saturation constants.
- One sub-module, eth_pattern_lane: one pattern's memory (data+mask), write port, async read at byte offset, run flag. Instantiated C_NUM_PATTERNS times by generate.

Test Plan:
- Pattern 0 = dst MAC FF:FF:FF:FF:FF:FF, mask FF for bytes 0-5, others 0; 64-byte broadcast frame -> bitmap=0001, length=64, valid 1 cycle after tlast, time = value at byte 0.
- Pattern 1 = 08 00 at offsets 12-13; frame with EtherType 0x0806 -> no result (REPORT_ALL off), overflow_count=0. With REPORT_ALL on -> bitmap=0000.
- Two back-to-back matching frames, m_match_ready held low -> first result held unchanged, overflow_count=1. Then ready=1 -> the first result is consumed.
- Frame with time_running=0 at first byte -> no result. Frame starting while running, with time_running dropped mid-frame -> result reported.
- tuser=1 on tlast of a matching frame -> fcs_err=1, bitmap reflects the match. Assert resetn low mid-frame -> outputs 0 immediately; the next frame is processed normally.
- cfg_we during a frame -> cfg_busy=1 and memory unchanged (readback via a subsequent match). 4-byte frame against a pattern masking bytes 0-9 with bytes 0-3 equal -> match.
